// File: rtl/branch_redirect_ctrl.sv
// branch_redirect_ctrl: gates the EX address builder, hands taken targets to fetch and squashes wrong-path work.
module branch_redirect_ctrl #(
  parameter int FLUSH_STAGES = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic             ex_is_jump,
  input  logic             ex_is_branch,
  input  logic             ex_take,
  input  logic [31:0]      ex_target,
  input  logic             fetch_ready,
  input  logic             clr_cnt,
  output logic             ab_en,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             flush,
  output logic             stall_ex,
  output logic             misalign_err,
  output logic             busy,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] taken_cnt
);
  typedef enum logic [1:0] {IDLE, REQ, FLUSH} state_e;
  state_e           state_q, state_d;
  logic [3:0]       fcnt_q, fcnt_d;
  logic [31:0]      pc_q, pc_d;
  logic             mis_q, mis_d;
  logic [CNT_W-1:0] bc_q, bc_d, tc_q, tc_d;
  logic             eval, take_ok;
  always_comb begin
    eval    = (state_q == IDLE) && ex_valid && (ex_is_jump || ex_is_branch);
    take_ok = eval && ex_take && (ex_target[1:0] == 2'b00);
    mis_d   = eval && ex_take && (ex_target[1:0] != 2'b00);
    pc_d    = take_ok ? ex_target : pc_q;
    state_d = state_q;
    fcnt_d  = fcnt_q;
    unique case (state_q)
      IDLE:  state_d = take_ok ? REQ : IDLE;
      REQ: begin
        state_d = fetch_ready ? FLUSH : REQ;
        fcnt_d  = fetch_ready ? 4'(FLUSH_STAGES - 1) : fcnt_q;
      end
      FLUSH: begin
        state_d = (fcnt_q == 4'd0) ? IDLE : FLUSH;
        fcnt_d  = (fcnt_q == 4'd0) ? fcnt_q : fcnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
    // Counters stick at all-ones; clear beats a same-cycle increment.
    bc_d = clr_cnt ? '0 : (eval && !(&bc_q)) ? bc_q + CNT_W'(1) : bc_q;
    tc_d = clr_cnt ? '0 : (take_ok && !(&tc_q)) ? tc_q + CNT_W'(1) : tc_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
      pc_q    <= '0;
      mis_q   <= 1'b0;
      bc_q    <= '0;
      tc_q    <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      pc_q    <= pc_d;
      mis_q   <= mis_d;
      bc_q    <= bc_d;
      tc_q    <= tc_d;
    end
  end
  assign ab_en          = (state_q == IDLE);
  assign busy           = (state_q != IDLE);
  assign redirect_valid = (state_q == REQ);
  assign stall_ex       = (state_q == REQ);
  assign flush          = (state_q != IDLE);
  assign redirect_pc    = pc_q;
  assign misalign_err   = mis_q;
  assign branch_cnt     = bc_q;
  assign taken_cnt      = tc_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb_branch_redirect_ctrl: directed and random stimulus checked every cycle against a behavioural model.
module tb_branch_redirect_ctrl;
  localparam int FS = 2;
  localparam int CW = 4;
  localparam int MAXC = (1 << CW) - 1;
  logic clk = 0, rst = 0;
  logic ex_valid = 0, ex_is_jump = 0, ex_is_branch = 0, ex_take = 0, fetch_ready = 0, clr_cnt = 0;
  logic [31:0] ex_target = 0;
  logic ab_en, redirect_valid, flush, stall_ex, misalign_err, busy;
  logic [31:0] redirect_pc;
  logic [CW-1:0] branch_cnt, taken_cnt;
  int nvec = 0, nerr = 0;
  bit m_req = 0, m_mis = 0;
  int m_fl = 0, m_bc = 0, m_tc = 0;
  logic [31:0] m_pc = 0;

  branch_redirect_ctrl #(.FLUSH_STAGES(FS), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_is_jump(ex_is_jump), .ex_is_branch(ex_is_branch),
    .ex_take(ex_take), .ex_target(ex_target), .fetch_ready(fetch_ready), .clr_cnt(clr_cnt),
    .ab_en(ab_en), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
    .stall_ex(stall_ex), .misalign_err(misalign_err), .busy(busy),
    .branch_cnt(branch_cnt), .taken_cnt(taken_cnt));

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set(input bit v, input bit j, input bit b, input bit t, input logic [31:0] tg, input bit fr, input bit c);
    ex_valid = v; ex_is_jump = j; ex_is_branch = b; ex_take = t; ex_target = tg; fetch_ready = fr; clr_cnt = c;
  endtask

  // Advance one clock: model consumes the inputs present at the edge, then every output is compared.
  task automatic cycle();
    bit idle, n_req, n_mis;
    int n_fl, n_bc, n_tc;
    logic [31:0] n_pc;
    idle = !m_req && m_fl == 0;
    n_req = m_req; n_fl = m_fl; n_bc = m_bc; n_tc = m_tc; n_pc = m_pc; n_mis = 0;
    if (!rst) begin
      n_req = 0; n_fl = 0; n_bc = 0; n_tc = 0; n_pc = 0;
    end else begin
      if (idle) begin
        if (ex_valid && (ex_is_jump || ex_is_branch)) begin
          n_bc = (m_bc < MAXC) ? m_bc + 1 : MAXC;
          if (ex_take) begin
            if (ex_target % 4 == 0) begin
              n_pc = ex_target; n_req = 1;
              n_tc = (m_tc < MAXC) ? m_tc + 1 : MAXC;
            end else n_mis = 1;
          end
        end
      end else if (m_req) begin
        if (fetch_ready) begin n_req = 0; n_fl = FS; end
      end else n_fl = m_fl - 1;
      if (clr_cnt) begin n_bc = 0; n_tc = 0; end
    end
    @(posedge clk);
    m_req = n_req; m_fl = n_fl; m_bc = n_bc; m_tc = n_tc; m_pc = n_pc; m_mis = n_mis;
    @(negedge clk);
    idle = !m_req && m_fl == 0;
    cmp("ab_en", {31'd0, ab_en}, {31'd0, idle});
    cmp("busy", {31'd0, busy}, {31'd0, !idle});
    cmp("redirect_valid", {31'd0, redirect_valid}, {31'd0, m_req});
    cmp("stall_ex", {31'd0, stall_ex}, {31'd0, m_req});
    cmp("flush", {31'd0, flush}, {31'd0, !idle});
    cmp("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
    cmp("redirect_pc", redirect_pc, m_pc);
    cmp("branch_cnt", 32'(branch_cnt), 32'(m_bc));
    cmp("taken_cnt", 32'(taken_cnt), 32'(m_tc));
  endtask

  initial begin
    rst = 0;
    repeat (2) cycle();
    rst = 1;
    cycle();
    // Taken branch to 0x100 accepted immediately.
    set(1, 0, 1, 1, 32'h100, 1, 0); cycle();
    cmp("t2_rv", {31'd0, redirect_valid}, 32'd1);
    cmp("t2_pc", redirect_pc, 32'h100);
    set(0, 0, 0, 0, 0, 1, 0); cycle();
    cmp("t2_flush1", {31'd0, flush & ~redirect_valid}, 32'd1);
    cycle();
    cmp("t2_flush2", {31'd0, flush}, 32'd1);
    cycle();
    cmp("t2_aben", {31'd0, ab_en & ~flush}, 32'd1);
    cmp("t2_tc", 32'(taken_cnt), 32'd1);
    cmp("t2_bc", 32'(branch_cnt), 32'd1);
    // Backpressure: REQ held five cycles.
    set(1, 1, 0, 1, 32'h2000, 0, 0); cycle();
    set(0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cmp("t3_stall", {31'd0, stall_ex & redirect_valid}, 32'd1);
      cmp("t3_pc", redirect_pc, 32'h2000);
      if (i < 4) cycle();
    end
    fetch_ready = 1; cycle();
    cmp("t3_accepted", {31'd0, flush & ~redirect_valid}, 32'd1);
    repeat (2) cycle();
    // Four not-taken branches.
    set(0, 0, 0, 0, 0, 0, 1); cycle();
    for (int i = 0; i < 4; i++) begin
      set(1, 0, 1, 0, 32'h400, 1, 0); cycle();
      cmp("t4_noflush", {31'd0, flush | redirect_valid}, 32'd0);
    end
    cmp("t4_bc", 32'(branch_cnt), 32'd4);
    cmp("t4_tc", 32'(taken_cnt), 32'd0);
    // Misaligned jump, then takes ignored while busy.
    set(1, 1, 0, 1, 32'h102, 1, 0); cycle();
    cmp("t5_mis", {31'd0, misalign_err}, 32'd1);
    cmp("t5_rv", {31'd0, redirect_valid}, 32'd0);
    set(0, 0, 0, 0, 0, 1, 0); cycle();
    cmp("t5_mis_end", {31'd0, misalign_err}, 32'd0);
    cmp("t5_tc", 32'(taken_cnt), 32'd0);
    set(1, 0, 1, 1, 32'h40, 1, 0); cycle();
    set(1, 1, 1, 1, 32'h80, 1, 0);
    repeat (3) cycle();
    cmp("t5_tc2", 32'(taken_cnt), 32'd1);
    cmp("t5_bc", 32'(branch_cnt), 32'd6);
    cmp("t5_pc", redirect_pc, 32'h40);
    // Saturation, then clear with a simultaneous take.
    set(0, 0, 0, 0, 0, 0, 1); cycle();
    set(1, 0, 1, 0, 0, 0, 0);
    repeat (20) cycle();
    cmp("t6_sat", 32'(branch_cnt), 32'd15);
    set(1, 0, 1, 1, 32'h200, 0, 1); cycle();
    cmp("t6_clr_bc", 32'(branch_cnt), 32'd0);
    cmp("t6_clr_tc", 32'(taken_cnt), 32'd0);
    set(0, 0, 0, 0, 0, 1, 0);
    repeat (3) cycle();
    // Reset while a redirect is pending.
    set(1, 1, 0, 1, 32'h300, 0, 0); cycle();
    set(0, 0, 0, 0, 0, 0, 0);
    rst = 0;
    repeat (3) cycle();
    rst = 1; cycle();
    cmp("t1_rv", {31'd0, redirect_valid}, 32'd0);
    cmp("t1_aben", {31'd0, ab_en}, 32'd1);
    cmp("t1_cnt", 32'({branch_cnt, taken_cnt}), 32'd0);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      ex_valid = ($urandom_range(3) != 0);
      ex_is_jump = $urandom_range(1);
      ex_is_branch = $urandom_range(1);
      ex_take = $urandom_range(1);
      ex_target = $urandom;
      if ($urandom_range(3) != 0) ex_target[1:0] = 2'b00;
      fetch_ready = $urandom_range(1);
      clr_cnt = ($urandom_range(19) == 0);
      rst = ($urandom_range(49) != 0);
      cycle();
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
